// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// opcode constants, datapath select encodings and the control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_sel;
        logic       done;
        logic       illegal;
    } ctrl_t;

    // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // Execution state entered from DECODE; FETCH marks an unknown opcode.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                          return S_R_EXEC;
            OP_LW, OP_SW:                      return S_MEM_ADDR;
            OP_BEQ, OP_BNE:                    return S_BRANCH;
            OP_J:                              return S_JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return S_I_EXEC;
            default:                           return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decode for the multicycle controller.
// Only the memory handshake, branch condition and opcode qualify the word;
// everything not set here stays 0.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Build the datapath control word for the current state.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_rd    = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.pc_we     = mem_ready_i;
                ctrl_o.ir_we     = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_sel   = is_zero_ext(op_i);
                ctrl_o.illegal   = (decode_target(op_i) == S_FETCH);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_rd = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_wr = 1'b1;
                ctrl_o.iord   = 1'b1;
                ctrl_o.done   = mem_ready_i;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = 1'b1;
                ctrl_o.done    = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.pc_we     = ((op_i == OP_BEQ) &&  zero_i) ||
                                   ((op_i == OP_BNE) && !zero_i);
                ctrl_o.done      = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src = PCSRC_JUMP;
                ctrl_o.pc_we  = 1'b1;
                ctrl_o.done   = 1'b1;
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_IMM;
                ctrl_o.ext_sel   = is_zero_ext(op_i);
            end
            S_I_WB: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.done    = 1'b1;
                ctrl_o.ext_sel = is_zero_ext(op_i);
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle processor controller: Moore FSM state register and next-state
// logic; the control word comes from mc_ctrl_decode. While reset is held all
// outputs are forced low so the datapath sees no strobe until release.
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_we_o,
    output logic       ir_we_o,
    output logic       iord_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       reg_we_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       ext_sel_o,
    output logic [3:0] state_o,
    output logic       done_o,
    output logic       illegal_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    // funct is consumed by ALU control downstream, never by sequencing.
    logic unused_funct;
    assign unused_funct = ^funct_i;

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (op_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    // Next-state logic: memory states wait on mem_ready_i, the rest advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready_i) state_d = S_DECODE;
            S_DECODE:    state_d = decode_target(op_i);
            S_MEM_ADDR:  begin
                if (op_i == OP_LW)      state_d = S_MEM_READ;
                else if (op_i == OP_SW) state_d = S_MEM_WRITE;
                else                    state_d = S_FETCH;
            end
            S_MEM_READ:  if (mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready_i) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // State register with asynchronous return to FETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Blank the control word while reset is asserted.
    always_comb begin
        ctrl_out = ctrl;
        if (rst_i) ctrl_out = '0;
    end

    assign pc_we_o      = ctrl_out.pc_we;
    assign ir_we_o      = ctrl_out.ir_we;
    assign iord_o       = ctrl_out.iord;
    assign mem_rd_o     = ctrl_out.mem_rd;
    assign mem_wr_o     = ctrl_out.mem_wr;
    assign reg_we_o     = ctrl_out.reg_we;
    assign reg_dst_o    = ctrl_out.reg_dst;
    assign mem_to_reg_o = ctrl_out.mem_to_reg;
    assign alu_src_a_o  = ctrl_out.alu_src_a;
    assign alu_src_b_o  = ctrl_out.alu_src_b;
    assign alu_op_o     = ctrl_out.alu_op;
    assign pc_src_o     = ctrl_out.pc_src;
    assign ext_sel_o    = ctrl_out.ext_sel;
    assign done_o       = ctrl_out.done;
    assign illegal_o    = ctrl_out.illegal;
    assign state_o      = state_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: op_i  in  6  opcode from instruction register; funct_i  in  6  R-type function field.
REQ-004 SHALL have: zero_i  in  1  ALU zero flag; mem_ready_i  in  1  memory access complete this cycle.
REQ-005 SHALL have outputs: pc_we_o, ir_we_o, iord_o, mem_rd_o, mem_wr_o, reg_we_o, reg_dst_o, mem_to_reg_o, alu_src_a_o  out  1 each  datapath strobes/selects.
REQ-006 SHALL have: alu_src_b_o  out  2  (00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2).
REQ-007 SHALL have: alu_op_o  out  2  (00 add, 01 sub, 10 funct decode, 11 opcode-immediate); pc_src_o  out  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-008 SHALL have: ext_sel_o  out  1  extender mode, 0 sign, 1 zero; state_o  out  4  current state; done_o  out  1  instruction retire pulse; illegal_o  out  1  unknown-opcode pulse.

Function
REQ-009 SHALL implement a Moore FSM, states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
REQ-010 FETCH: mem_rd_o=1, iord_o=0, alu_src_b_o=01, alu_op_o=00, pc_src_o=00; pc_we_o and ir_we_o SHALL be 1 only in the cycle mem_ready_i=1; state holds FETCH until then, then DECODE.
REQ-011 DECODE: alu_src_b_o=11, alu_op_o=00 (branch target); next state by op_i: 0x00->R_EXEC, 0x23/0x2B->MEM_ADDR, 0x04/0x05->BRANCH, 0x02->JUMP, 0x08/0x0A/0x0C/0x0D->I_EXEC, any other->FETCH with illegal_o=1 for that cycle.
REQ-012 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00; next MEM_READ for 0x23, MEM_WRITE for 0x2B.
REQ-013 MEM_READ: mem_rd_o=1, iord_o=1; hold until mem_ready_i=1, then MEM_WB.
REQ-014 MEM_WB: reg_we_o=1, mem_to_reg_o=1, reg_dst_o=0; done_o=1; next FETCH.
REQ-015 MEM_WRITE: mem_wr_o=1, iord_o=1; hold until mem_ready_i=1; done_o=1 in completing cycle; then FETCH.
REQ-016 R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10; next R_WB. R_WB: reg_we_o=1, reg_dst_o=1, mem_to_reg_o=0, done_o=1; next FETCH.
REQ-017 I_EXEC: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=11; next I_WB. I_WB: reg_we_o=1, reg_dst_o=0, done_o=1; next FETCH.
REQ-018 BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_src_o=01; pc_we_o=(op_i==0x04 & zero_i)|(op_i==0x05 & ~zero_i); done_o=1; next FETCH.
REQ-019 JUMP: pc_src_o=10, pc_we_o=1, done_o=1; next FETCH.
REQ-020 ext_sel_o SHALL be 1 when op_i is 0x0C or 0x0D in DECODE, I_EXEC, I_WB; 0 otherwise.
REQ-021 Any strobe not listed for a state SHALL be 0; selects not listed SHALL be 0.
REQ-022 mem_rd_o and mem_wr_o SHALL never be 1 simultaneously; reg_we_o and pc_we_o SHALL never both be 1.
REQ-023 funct_i SHALL not affect sequencing (passed through only via alu_op_o=10 to ALU control).

Reset
REQ-024 rst_i=1 SHALL force state to FETCH asynchronously, including mid-instruction or mid-memory-wait.
REQ-025 While rst_i=1 all outputs SHALL be 0 (state_o=0); FETCH outputs SHALL appear from the first cycle after release.

Structure
REQ-026 State encodings, opcode constants, alu_src_b/alu_op/pc_src encodings SHALL live in shared package mc_ctrl_pkg.
REQ-027 State-to-control-word decode SHALL be sub-module mc_ctrl_decode (combinational); mc_control holds state register and next-state logic.

Verification
REQ-028 Reset release, mem_ready_i=1 constant, op_i=0x00 -> states 0,1,6,7; done_o and reg_we_o high in 4th cycle.
REQ-029 lw (0x23), mem_ready_i low 3 cycles in MEM_READ -> state 3 held 4 cycles, mem_rd_o=1/iord_o=1 throughout, then 4 with reg_we_o=1.
REQ-030 beq (0x04) zero_i=1 -> pc_we_o=1, pc_src_o=01 in state 8; repeat zero_i=0 -> pc_we_o=0; bne (0x05) inverse.
REQ-031 ori (0x0D) -> ext_sel_o=1 in states 1,10,11; addi (0x08) -> ext_sel_o=0.
REQ-032 op_i=0x3F -> illegal_o one-cycle pulse in DECODE, next state 0, no reg_we_o/mem_wr_o.
REQ-033 rst_i asserted during MEM_WRITE wait -> state_o=0 and mem_wr_o=0 same cycle, before next clock edge.
